// File: rtl/data_cache_refill_pkg.sv
// Shared definitions for the data cache refill engine: address-field split,
// block geometry and the refill FSM encoding.
package data_cache_refill_pkg;

    // Words per cache block (beats per refill)
    localparam int BLOCK_WORDS  = 16;
    localparam int TAG_W        = 22;
    localparam int INDEX_W      = 4;
    localparam int WORD_OFF_W   = 4;
    localparam int BYTE_OFF_W   = 2;
    localparam int BLOCK_ADDR_W = TAG_W + INDEX_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LAST,
        ST_DONE
    } refill_state_e;

    typedef logic [WORD_OFF_W-1:0]   beat_t;
    typedef logic [BLOCK_ADDR_W-1:0] block_addr_t;

    function automatic logic [31:0] beat_address(input block_addr_t block, input beat_t beat);
        return {block, beat, {BYTE_OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/data_cache_refill.sv
// Data cache refill engine: on a miss, reads the whole 16-word block from
// data memory one beat at a time and streams registered line writes to the cache.
module data_cache_refill
    import data_cache_refill_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = BLOCK_WORDS,
    parameter int INDEX_BITS      = INDEX_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  miss,
    input  logic [31:0]           missAddress,
    output logic                  memRequest,
    output logic [31:0]           memAddress,
    input  logic                  memReady,
    input  logic [31:0]           memReadData,
    output logic                  fillWrite,
    output logic [INDEX_BITS-1:0] fillIndex,
    output logic [WORD_OFF_W-1:0] fillWordOffset,
    output logic [TAG_W-1:0]      fillTag,
    output logic [31:0]           fillData,
    output logic                  stall,
    output logic                  refillDone
);

    // The beat that, once accepted in FETCH, hands over to LAST
    localparam beat_t PENULT_BEAT = beat_t'(WORDS_PER_BLOCK - 2);

    refill_state_e   state_q, state_d;
    block_addr_t     block_q, block_d;
    beat_t           beat_q, beat_d;
    logic            fill_write_q, fill_write_d;
    beat_t           fill_offset_q, fill_offset_d;
    logic [31:0]     fill_data_q, fill_data_d;

    logic            fetching;
    logic            beat_done;

    // Byte-within-block bits never reach the refill datapath
    logic            unused_byte_bits;
    assign unused_byte_bits = ^missAddress[31-BLOCK_ADDR_W:0];

    assign fetching  = (state_q == ST_FETCH) || (state_q == ST_LAST);
    assign beat_done = fetching && memReady;

    // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d       = state_q;
        block_d       = block_q;
        beat_d        = beat_q;
        fill_write_d  = 1'b0;
        fill_offset_d = fill_offset_q;
        fill_data_d   = fill_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (miss) begin
                    block_d = missAddress[31 -: BLOCK_ADDR_W];
                    beat_d  = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (beat_done) begin
                    beat_d = beat_q + beat_t'(1);
                    if (beat_q == PENULT_BEAT) begin
                        state_d = ST_LAST;
                    end
                end
            end
            ST_LAST: begin
                if (beat_done) begin
                    beat_d  = beat_q + beat_t'(1);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Each accepted beat becomes a one-cycle line write on the next cycle
        if (beat_done) begin
            fill_write_d  = 1'b1;
            fill_offset_d = beat_q;
            fill_data_d   = memReadData;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            block_q       <= '0;
            beat_q        <= '0;
            fill_write_q  <= 1'b0;
            fill_offset_q <= '0;
            fill_data_q   <= '0;
        end else begin
            state_q       <= state_d;
            block_q       <= block_d;
            beat_q        <= beat_d;
            fill_write_q  <= fill_write_d;
            fill_offset_q <= fill_offset_d;
            fill_data_q   <= fill_data_d;
        end
    end

    assign memRequest     = fetching;
    assign memAddress     = fetching ? beat_address(block_q, beat_q) : 32'h0;
    assign fillIndex      = block_q[INDEX_BITS-1:0];
    assign fillTag        = block_q[BLOCK_ADDR_W-1 -: TAG_W];
    assign fillWrite      = fill_write_q;
    assign fillWordOffset = fill_offset_q;
    assign fillData       = fill_data_q;
    assign refillDone     = (state_q == ST_DONE);
    assign stall          = ((state_q == ST_IDLE) && miss) || fetching;

endmodule

// File: tb/tb_data_cache_refill.sv
// Directed bench for data_cache_refill: each task drives one scenario and
// compares outputs against hand-computed addresses, fields and a beat scoreboard.
module tb_data_cache_refill;

    logic        clock = 1'b0;
    logic        reset;
    logic        miss;
    logic [31:0] missAddress;
    logic        memRequest;
    logic [31:0] memAddress;
    logic        memReady;
    logic [31:0] memReadData;
    logic        fillWrite;
    logic [3:0]  fillIndex;
    logic [3:0]  fillWordOffset;
    logic [21:0] fillTag;
    logic [31:0] fillData;
    logic        stall;
    logic        refillDone;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    data_cache_refill dut (
        .clock          (clock),
        .reset          (reset),
        .miss           (miss),
        .missAddress    (missAddress),
        .memRequest     (memRequest),
        .memAddress     (memAddress),
        .memReady       (memReady),
        .memReadData    (memReadData),
        .fillWrite      (fillWrite),
        .fillIndex      (fillIndex),
        .fillWordOffset (fillWordOffset),
        .fillTag        (fillTag),
        .fillData       (fillData),
        .stall          (stall),
        .refillDone     (refillDone)
    );

    function automatic logic [31:0] data_of(input logic [31:0] seed, input int k);
        return seed + 32'(k) * 32'h1000_0011;
    endfunction

    task automatic test_reset();
        reset = 1'b1; miss = 1'b0; missAddress = 32'h0;
        memReady = 1'b1; memReadData = 32'hFFFF_FFFF;
        repeat (2) @(negedge clock);
        #1;
        tests_run++;
        if ({memRequest, fillWrite, refillDone, stall} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 0000", {memRequest, fillWrite, refillDone, stall});
        end
        tests_run++;
        if ({memAddress, fillIndex, fillWordOffset, fillTag, fillData} !== 94'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h expected 0", {memAddress, fillIndex, fillWordOffset, fillTag, fillData});
        end
        miss = 1'b1;
        #1;
        tests_run++;
        if ({stall, memRequest} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_idle_miss_stall: got %b expected 10", {stall, memRequest});
        end
        miss = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #1;
            tests_run++;
            if ({memRequest, fillWrite, refillDone, stall} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL idle_quiet_%0d: got %b expected 0000", i, {memRequest, fillWrite, refillDone, stall});
            end
        end
    endtask

    // mode 0: memReady always 1; 1: memReady 1,0,1,0...; 2: miss drops after beat 3;
    // 3: missAddress jumps to 0xFFFF_FFC0 from beat 5 on.
    task automatic do_refill(input string name, input logic [31:0] addr, input logic [31:0] base,
                             input logic [3:0] idx, input logic [21:0] tg, input int mode,
                             input logic hold_miss);
        logic [31:0] seed;
        logic [60:0] act_c, exp_c;
        logic [36:0] act_f, exp_f;
        logic        pend, rdy;
        logic [3:0]  pend_off;
        logic [31:0] pend_data;
        int          beat, cycles, fills;
        seed = addr ^ 32'h5A5A_A5A5;
        beat = 0; cycles = 0; fills = 0;
        pend = 1'b0; pend_off = 4'h0; pend_data = 32'h0;

        @(negedge clock);
        miss = 1'b1; missAddress = addr; memReady = 1'b1; memReadData = 32'hDEAD_BEEF;
        #1;
        tests_run++;
        if ({stall, memRequest, fillWrite, refillDone} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL %s idle_miss: got %b expected 1000", name, {stall, memRequest, fillWrite, refillDone});
        end

        while (beat < 16 && cycles < 100) begin
            @(negedge clock);
            cycles++;
            rdy = (mode == 1) ? cycles[0] : 1'b1;
            if (mode == 2 && beat > 3) miss = 1'b0;
            if (mode == 3 && beat >= 5) missAddress = 32'hFFFF_FFC0;
            memReady    = rdy;
            memReadData = rdy ? data_of(seed, beat) : ~data_of(seed, beat);
            #1;
            act_c = {memRequest, memAddress, stall, refillDone, fillIndex, fillTag};
            exp_c = {1'b1, base + 32'(4 * beat), 1'b1, 1'b0, idx, tg};
            tests_run++;
            if (act_c !== exp_c) begin
                tests_failed++;
                $display("FAIL %s beat_%0d ctrl: got %h expected %h", name, beat, act_c, exp_c);
            end
            if (fillWrite === 1'b1) fills++;
            act_f = {fillWrite, fillWordOffset, fillData};
            exp_f = {1'b1, pend_off, pend_data};
            tests_run++;
            if (pend && act_f !== exp_f) begin
                tests_failed++;
                $display("FAIL %s fill_%0d: got %h expected %h", name, pend_off, act_f, exp_f);
            end else if (!pend && fillWrite !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s fill_idle_c%0d: got %b expected 0", name, cycles, fillWrite);
            end
            pend      = rdy;
            pend_off  = 4'(beat);
            pend_data = data_of(seed, beat);
            if (rdy) beat++;
        end
        tests_run++;
        if (beat != 16) begin
            tests_failed++;
            $display("FAIL %s timeout: got %0d beats expected 16", name, beat);
        end

        @(negedge clock);
        miss = hold_miss; memReady = 1'b1;
        #1;
        tests_run++;
        if ({refillDone, memRequest, stall, fillIndex, fillTag} !== {1'b1, 1'b0, 1'b0, idx, tg}) begin
            tests_failed++;
            $display("FAIL %s done: got %h expected %h", name,
                     {refillDone, memRequest, stall, fillIndex, fillTag}, {1'b1, 1'b0, 1'b0, idx, tg});
        end
        if (fillWrite === 1'b1) fills++;
        tests_run++;
        if ({fillWrite, fillWordOffset, fillData} !== {1'b1, 4'hF, data_of(seed, 15)}) begin
            tests_failed++;
            $display("FAIL %s last_fill: got %h expected %h", name,
                     {fillWrite, fillWordOffset, fillData}, {1'b1, 4'hF, data_of(seed, 15)});
        end
        tests_run++;
        if (fills != 16) begin
            tests_failed++;
            $display("FAIL %s fill_count: got %0d expected 16", name, fills);
        end
        tests_run++;
        if (cycles != ((mode == 1) ? 31 : 16)) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d beat cycles expected %0d", name, cycles, (mode == 1) ? 31 : 16);
        end

        if (!hold_miss) begin
            @(negedge clock);
            #1;
            tests_run++;
            if ({stall, memRequest, refillDone, fillWrite} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL %s post_idle: got %b expected 0000", name, {stall, memRequest, refillDone, fillWrite});
            end
        end
    endtask

    task automatic test_basic_refill();
        do_refill("basic", 32'h0000_1A74, 32'h0000_1A40, 4'd9, 22'h6, 0, 1'b0);
    endtask

    task automatic test_ready_toggle();
        do_refill("toggle", 32'h8000_0100, 32'h8000_0100, 4'd4, 22'h20_0000, 1, 1'b0);
    endtask

    task automatic test_miss_drop();
        do_refill("miss_drop", 32'h0000_0FFC, 32'h0000_0FC0, 4'hF, 22'h3, 2, 1'b0);
    endtask

    task automatic test_addr_change();
        do_refill("addr_change", 32'h0012_3480, 32'h0012_3480, 4'd2, 22'h48D, 3, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_refill("b2b_first", 32'h1234_5678, 32'h1234_5640, 4'd9, 22'h4_8D15, 0, 1'b1);
        do_refill("b2b_second", 32'hFFFF_FFC0, 32'hFFFF_FFC0, 4'hF, 22'h3F_FFFF, 0, 1'b0);
    endtask

    task automatic test_reset_abort();
        logic [31:0] seed;
        seed = 32'h0000_2000 ^ 32'h5A5A_A5A5;
        @(negedge clock);
        miss = 1'b1; missAddress = 32'h0000_2000; memReady = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            memReadData = data_of(seed, k);
        end
        @(negedge clock);
        miss = 1'b0; memReadData = data_of(seed, 7);
        #1;
        tests_run++;
        if ({memRequest, memAddress, fillTag} !== {1'b1, 32'h0000_201C, 22'h8}) begin
            tests_failed++;
            $display("FAIL abort_at_beat7: got %h expected %h", {memRequest, memAddress, fillTag}, {1'b1, 32'h0000_201C, 22'h8});
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({memRequest, fillWrite, stall, refillDone, memAddress, fillTag, fillIndex} !== 61'd0) begin
            tests_failed++;
            $display("FAIL abort_in_reset: got %h expected 0",
                     {memRequest, fillWrite, stall, refillDone, memAddress, fillTag, fillIndex});
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if ({memRequest, fillWrite, stall, refillDone} !== 4'b0000) begin
                tests_failed++;
                $display("FAIL abort_after_%0d: got %b expected 0000", i, {memRequest, fillWrite, stall, refillDone});
            end
            @(negedge clock);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; miss = 1'b0; missAddress = 32'h0;
        memReady = 1'b0; memReadData = 32'h0;
        test_reset();
        test_basic_refill();
        test_ready_toggle();
        test_miss_drop();
        test_reset_abort();
        test_addr_change();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
